// File: rtl/mem_word_port.sv
// mem_word_port: 32-bit word port onto an 8-bit byte memory, one byte per cycle, little-endian.
// Defining MEM_WORD_PORT_BYTE_EN adds req_byte for single-byte transfers.
module mem_word_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_WORD_PORT_BYTE_EN
  input  logic        req_byte,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        memwrite,
  output logic [7:0]  adr,
  output logic [7:0]  writedata,
  input  logic [7:0]  memdata
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [7:0]  adr_r, adr_s;
  logic [7:0]  writedata_r, writedata_s;
  logic        memwrite_r, memwrite_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [31:0] rsp_rdata_r, rsp_rdata_s;
  logic [23:0] wdata_hi_r, wdata_hi_s;
  logic        write_r, write_s;
  logic        byte_r, byte_s;
  logic [23:0] rbuf_r, rbuf_s;
  logic        last_s;
  logic        req_byte_s;

`ifdef MEM_WORD_PORT_BYTE_EN
  assign req_byte_s = req_byte;
`else
  assign req_byte_s = 1'b0;
`endif

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign memwrite  = memwrite_r;
  assign adr       = adr_r;
  assign writedata = writedata_r;

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    adr_s       = adr_r;
    writedata_s = writedata_r;
    memwrite_s  = memwrite_r;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    wdata_hi_s  = wdata_hi_r;
    write_s     = write_r;
    byte_s      = byte_r;
    rbuf_s      = rbuf_r;
    last_s      = (cnt_r == 2'd3) || byte_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s     = XFER;
          cnt_s       = 2'd0;
          adr_s       = req_addr;
          memwrite_s  = req_write;
          writedata_s = req_wdata[7:0];
          wdata_hi_s  = req_wdata[31:8];
          write_s     = req_write;
          byte_s      = req_byte_s;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        // memdata holds the byte fetched at the preceding negedge
        case (cnt_r)
          2'd0:    rbuf_s[7:0]   = memdata;
          2'd1:    rbuf_s[15:8]  = memdata;
          2'd2:    rbuf_s[23:16] = memdata;
          default: rbuf_s        = rbuf_r;
        endcase
        if (last_s) begin
          state_s     = IDLE;
          memwrite_s  = 1'b0;
          rsp_valid_s = 1'b1;
          if (write_r) begin
            rsp_rdata_s = rsp_rdata_r;
          end else if (byte_r) begin
            rsp_rdata_s = {24'h000000, memdata};
          end else begin
            rsp_rdata_s = {memdata, rbuf_r[23:0]};
          end
        end else begin
          state_s = XFER;
          adr_s   = adr_r + 8'd1;
          cnt_s   = cnt_r + 2'd1;
          case (cnt_r)
            2'd0:    writedata_s = wdata_hi_r[7:0];
            2'd1:    writedata_s = wdata_hi_r[15:8];
            2'd2:    writedata_s = wdata_hi_r[23:16];
            default: writedata_s = writedata_r;
          endcase
        end
      end
      default: begin
        state_s    = IDLE;
        memwrite_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      adr_r       <= 8'h00;
      writedata_r <= 8'h00;
      memwrite_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h00000000;
      wdata_hi_r  <= 24'h000000;
      write_r     <= 1'b0;
      byte_r      <= 1'b0;
      rbuf_r      <= 24'h000000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      adr_r       <= adr_s;
      writedata_r <= writedata_s;
      memwrite_r  <= memwrite_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      wdata_hi_r  <= wdata_hi_s;
      write_r     <= write_s;
      byte_r      <= byte_s;
      rbuf_r      <= rbuf_s;
    end
  end

endmodule

// File: doc/mem_word_port.md
MEM_WORD_PORT -- requirements
Module: mem_word_port

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32-bit word, 8-bit byte, 8-bit address.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: word-transaction request.
REQ-005 SHALL have port req_ready, output, 1: block idle and accepting.
REQ-006 SHALL have port req_write, input, 1: 1 = word write, 0 = word read.
REQ-007 SHALL have port req_addr, input, 8: byte address of byte 0; alignment not required.
REQ-008 SHALL have port req_wdata, input, 32: write word.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32: assembled read word.
REQ-011 SHALL have port memwrite, output, 1: byte-memory write strobe.
REQ-012 SHALL have port adr, output, 8: byte-memory address.
REQ-013 SHALL have port writedata, output, 8: byte-memory write data.
REQ-014 SHALL have port memdata, input, 8: byte-memory read data; memory updates it on negedge clk from adr.

Function
REQ-015 SHALL implement an FSM with states IDLE and XFER, plus a 2-bit byte counter cnt.
REQ-016 SHALL assert req_ready iff state is IDLE; a request is accepted on a posedge where req_valid && req_ready.
REQ-017 On acceptance, SHALL register adr<=req_addr, memwrite<=req_write, writedata<=req_wdata[7:0], latch req_wdata and req_write, set cnt<=0, and enter XFER.
REQ-018 In XFER with cnt=k, the memory access for byte k SHALL occur at the intervening negedge.
REQ-019 On a read, at the posedge ending cnt=k, SHALL capture memdata into bits [8k+7:8k]; byte order is little-endian.
REQ-020 If k<3, SHALL set adr<=adr+1 (mod 256, wrapping 0xFF->0x00), writedata<=wdata byte k+1, cnt<=k+1.
REQ-021 If k=3, SHALL set memwrite<=0, enter IDLE, and pulse rsp_valid=1 for exactly one cycle.
REQ-022 On a read completion, SHALL update rsp_rdata with the assembled word in the same cycle as rsp_valid; rsp_rdata then holds until the next read completes.
REQ-023 On a write completion, SHALL pulse rsp_valid and leave rsp_rdata unchanged.
REQ-024 Latency SHALL be: rsp_valid high in the cycle following the 4th posedge after the acceptance edge.
REQ-025 A new request SHALL be acceptable in the same cycle rsp_valid is high, giving back-to-back throughput of one word per 5 cycles.
REQ-026 SHALL ignore req_valid, req_addr, req_write and req_wdata while in XFER.
REQ-027 memwrite SHALL be high only during XFER cycles of a write transaction, exactly 4 cycles per write.
REQ-028 SHALL hold adr and writedata at their last values while IDLE.

Reset
REQ-029 On a posedge with reset=0, SHALL force state=IDLE, cnt=0, memwrite=0, adr=0x00, writedata=0x00, rsp_valid=0, rsp_rdata=0x00000000; req_ready=1 after release.
REQ-030 Reset mid-transaction SHALL abort it: no rsp_valid, no further memory writes after that edge; bytes already written remain written.
REQ-031 No request SHALL be accepted on a posedge with reset=0.

Configuration
REQ-032 Macro MEM_WORD_PORT_BYTE_EN, when defined, SHALL add input req_byte (1 bit).
REQ-033 With MEM_WORD_PORT_BYTE_EN and req_byte=1, SHALL transfer one byte only (XFER for cnt=0 only), with rsp_valid 1 cycle after the acceptance edge.
REQ-034 With MEM_WORD_PORT_BYTE_EN and req_byte=1, a read SHALL return rsp_rdata = {24'h0, byte}, and a write SHALL write req_wdata[7:0] only.
REQ-035 Without MEM_WORD_PORT_BYTE_EN, the req_byte port SHALL be absent and all transactions SHALL be 4 bytes.

Verification
REQ-036 Memory preloaded 0x10..0x13 = 11,22,33,44; read req_addr=0x10 -> rsp_valid 5th cycle after accept, rsp_rdata=0x44332211.
REQ-037 Write req_addr=0x20, req_wdata=0xDEADBEEF -> memwrite high 4 cycles, adr 0x20..0x23, writedata EF,BE,AD,DE; read-back returns 0xDEADBEEF.
REQ-038 Read req_addr=0xFE with memory FE=01, FF=02, 00=03, 01=04 -> adr sequence FE,FF,00,01; rsp_rdata=0x04030201.
REQ-039 Hold req_valid high for two reads (0x10 then 0x20) -> second accepted in the rsp_valid cycle of the first; req_ready low while in XFER; mid-XFER req changes ignored.
REQ-040 Assert reset low during cnt=1 of a write to 0x30 -> bytes 0x30..0x31 written, 0x32..0x33 unchanged, no rsp_valid, outputs at reset values.
REQ-041 With MEM_WORD_PORT_BYTE_EN, byte read 0x12 -> rsp_rdata=0x00000033, latency 1 cycle.
